// File: rtl/keypad_encoder_sync.sv
// keypad_encoder_sync: synchronised, debounced one-hot keypad encoder with press strobe and multi-key error
module keypad_encoder_sync #(
    parameter int N_KEYS = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CODE_W = $clog2(N_KEYS)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] keyboard,
    input  logic              enablen,
    output logic [CODE_W-1:0] BCD,
    output logic              valid,
    output logic              strobe,
    output logic              error
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, DEBOUNCE, PRESSED, LOCKOUT, RELEASE} state_t;

    state_t state, state_n;
    logic [N_KEYS-1:0] sync1, ks, cap, cap_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CODE_W-1:0] bcd_n, idx;
    logic valid_n, strobe_n, error_n, single, counting;

    assign single = (cap != '0) && ((cap & (cap - 1'b1)) == '0);
    assign counting = cnt < CNT_W'(DEBOUNCE_CYCLES - 1);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_KEYS; i++)
            if (cap[i]) idx = CODE_W'(i);
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        cap_n = cap;
        bcd_n = BCD;
        valid_n = valid;
        strobe_n = 1'b0;
        error_n = error;
        unique case (state)
            IDLE: if (ks != '0 && !enablen) begin
                cap_n = ks;
                cnt_n = '0;
                state_n = DEBOUNCE;
            end
            DEBOUNCE: if (enablen || ks == '0) state_n = IDLE;
            else if (ks != cap) begin
                cap_n = ks;
                cnt_n = '0;
            end else if (counting) cnt_n = cnt + 1'b1;
            else if (single) begin
                bcd_n = idx;
                valid_n = 1'b1;
                strobe_n = 1'b1;
                state_n = PRESSED;
            end else begin
                error_n = 1'b1;
                state_n = LOCKOUT;
            end
            PRESSED: if (ks != cap) begin
                cnt_n = '0;
                state_n = RELEASE;
            end
            LOCKOUT: if (ks == '0) begin
                cnt_n = '0;
                state_n = RELEASE;
            end
            RELEASE: if (ks != '0) cnt_n = '0;
            else if (counting) cnt_n = cnt + 1'b1;
            else begin
                valid_n = 1'b0;
                error_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            ks <= '0;
            state <= IDLE;
            cnt <= '0;
            cap <= '0;
            BCD <= '0;
            valid <= 1'b0;
            strobe <= 1'b0;
            error <= 1'b0;
        end else begin
            sync1 <= keyboard;
            ks <= sync1;
            state <= state_n;
            cnt <= cnt_n;
            cap <= cap_n;
            BCD <= bcd_n;
            valid <= valid_n;
            strobe <= strobe_n;
            error <= error_n;
        end
    end
endmodule

// File: tb/tb_keypad_encoder_sync.sv
// tb_keypad_encoder_sync: directed scenario tests for keypad_encoder_sync with default parameters
module tb_keypad_encoder_sync;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic [9:0] keyboard = '0;
    logic enablen = 1'b0;
    logic [3:0] BCD;
    logic valid, strobe, error;
    int checks = 0;
    int errors = 0;
    int nstb = 0;
    int s0;

    keypad_encoder_sync dut (
        .clock(clock), .resetn(resetn), .keyboard(keyboard), .enablen(enablen),
        .BCD(BCD), .valid(valid), .strobe(strobe), .error(error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (resetn && strobe) nstb++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks++; if ({BCD, valid, strobe, error} !== 7'd0) begin errors++; $display("FAIL reset outs got %b exp 0", {BCD, valid, strobe, error}); end
        @(negedge clock) resetn = 1'b1;
        cyc(3);
        checks++; if ({BCD, valid, strobe, error} !== 7'd0) begin errors++; $display("FAIL idle outs got %b exp 0", {BCD, valid, strobe, error}); end
    endtask

    task automatic test_press();
        s0 = nstb;
        keyboard = 10'b0010000000;
        cyc(6);
        checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL press early strobe got %b exp 0", strobe); end
        cyc(1);
        checks++; if (strobe !== 1'b1) begin errors++; $display("FAIL press strobe got %b exp 1", strobe); end
        checks++; if (BCD !== 4'd7) begin errors++; $display("FAIL press bcd got %0d exp 7", BCD); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL press valid got %b exp 1", valid); end
        cyc(1);
        checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL strobe width got %b exp 0", strobe); end
        cyc(12);
        keyboard = '0;
        cyc(6);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL release early valid got %b exp 1", valid); end
        cyc(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL release valid got %b exp 0", valid); end
        checks++; if (BCD !== 4'd7) begin errors++; $display("FAIL release bcd got %0d exp 7", BCD); end
        cyc(3);
        checks++; if (nstb - s0 !== 1) begin errors++; $display("FAIL press strobes got %0d exp 1", nstb - s0); end
    endtask

    task automatic test_bounce();
        s0 = nstb;
        for (int i = 0; i < 5; i++) begin
            keyboard = 10'b0000001000;
            cyc(2);
            keyboard = '0;
            cyc(2);
        end
        checks++; if (nstb - s0 !== 0) begin errors++; $display("FAIL bounce strobes got %0d exp 0", nstb - s0); end
        keyboard = 10'b0000001000;
        cyc(10);
        checks++; if (nstb - s0 !== 1) begin errors++; $display("FAIL bounce held strobes got %0d exp 1", nstb - s0); end
        checks++; if (BCD !== 4'd3) begin errors++; $display("FAIL bounce bcd got %0d exp 3", BCD); end
        keyboard = '0;
        cyc(10);
    endtask

    task automatic test_multi();
        s0 = nstb;
        keyboard = 10'b0000000110;
        cyc(6);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL multi early error got %b exp 0", error); end
        cyc(1);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL multi error got %b exp 1", error); end
        checks++; if (BCD !== 4'd3) begin errors++; $display("FAIL multi bcd got %0d exp 3", BCD); end
        checks++; if ({valid, strobe} !== 2'b00) begin errors++; $display("FAIL multi valid/strobe got %b exp 00", {valid, strobe}); end
        cyc(5);
        keyboard = '0;
        cyc(6);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL multi held error got %b exp 1", error); end
        cyc(1);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL multi clear error got %b exp 0", error); end
        checks++; if (nstb - s0 !== 0) begin errors++; $display("FAIL multi strobes got %0d exp 0", nstb - s0); end
        cyc(3);
    endtask

    task automatic test_enable();
        s0 = nstb;
        enablen = 1'b1;
        keyboard = 10'b0000100000;
        cyc(20);
        checks++; if (nstb - s0 !== 0) begin errors++; $display("FAIL disabled strobes got %0d exp 0", nstb - s0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL disabled valid got %b exp 0", valid); end
        keyboard = '0;
        cyc(4);
        enablen = 1'b0;
        cyc(4);
        keyboard = 10'b0000100000;
        cyc(10);
        checks++; if (nstb - s0 !== 1) begin errors++; $display("FAIL enabled strobes got %0d exp 1", nstb - s0); end
        checks++; if (BCD !== 4'd5) begin errors++; $display("FAIL enabled bcd got %0d exp 5", BCD); end
        keyboard = '0;
        cyc(10);
    endtask

    task automatic test_rollover();
        s0 = nstb;
        keyboard = 10'b0000000100;
        cyc(10);
        keyboard = 10'b1000000100;
        cyc(10);
        keyboard = 10'b1000000000;
        cyc(10);
        checks++; if (nstb - s0 !== 1) begin errors++; $display("FAIL rollover strobes got %0d exp 1", nstb - s0); end
        checks++; if (BCD !== 4'd2) begin errors++; $display("FAIL rollover bcd got %0d exp 2", BCD); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rollover valid got %b exp 1", valid); end
        keyboard = '0;
        cyc(10);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rollover release valid got %b exp 0", valid); end
        keyboard = 10'b1000000000;
        cyc(10);
        checks++; if (nstb - s0 !== 2) begin errors++; $display("FAIL repress strobes got %0d exp 2", nstb - s0); end
        checks++; if (BCD !== 4'd9) begin errors++; $display("FAIL repress bcd got %0d exp 9", BCD); end
        keyboard = '0;
        cyc(10);
    endtask

    task automatic test_reset_mid();
        keyboard = 10'b0000010000;
        cyc(4);
        #2 resetn = 1'b0;
        #1;
        checks++; if ({BCD, valid, strobe, error} !== 7'd0) begin errors++; $display("FAIL reset debounce outs got %b exp 0", {BCD, valid, strobe, error}); end
        @(negedge clock) resetn = 1'b1;
        s0 = nstb;
        cyc(6);
        checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL post reset early strobe got %b exp 0", strobe); end
        cyc(1);
        checks++; if ({strobe, BCD} !== 5'b10100) begin errors++; $display("FAIL post reset strobe/bcd got %b exp 10100", {strobe, BCD}); end
        cyc(5);
        #2 resetn = 1'b0;
        #1;
        checks++; if ({BCD, valid, strobe, error} !== 7'd0) begin errors++; $display("FAIL reset pressed outs got %b exp 0", {BCD, valid, strobe, error}); end
        @(negedge clock) resetn = 1'b1;
        cyc(7);
        checks++; if ({strobe, valid, BCD} !== 6'b110100) begin errors++; $display("FAIL second reset strobe/valid/bcd got %b exp 110100", {strobe, valid, BCD}); end
        cyc(2);
        checks++; if (nstb - s0 !== 2) begin errors++; $display("FAIL reset strobes got %0d exp 2", nstb - s0); end
        keyboard = '0;
        cyc(10);
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_multi();
        test_enable();
        test_rollover();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
